// File: rtl/parking_gate_scheduler.sv
// Round-robin arbiter that serializes gate entry/exit requests into the occupancy counter's single-event strobes.
// Optional macro PARKING_EXIT_PRIORITY_EN: pending exits are granted ahead of any entry.
module parking_gate_scheduler #(
  parameter int NUM_GATES        = 4,
  parameter int GATE_OPEN_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] req_valid,
  input  logic [NUM_GATES-1:0] req_dir,
  input  logic [NUM_GATES-1:0] req_uni,
  input  logic [9:0]           total_vacated_space,
  input  logic [9:0]           uni_vacated_space,
  output logic [NUM_GATES-1:0] req_ready,
  output logic [NUM_GATES-1:0] reject,
  output logic [NUM_GATES-1:0] gate_open,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic                 busy
);

  localparam int PW = $clog2(NUM_GATES);
  localparam int TW = $clog2(GATE_OPEN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, OPEN, SETTLE} state_t;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [TW-1:0]        timer;
  logic [NUM_GATES-1:0] cand;
  logic [NUM_GATES-1:0] win_onehot;
  logic [PW-1:0]        win;
  logic [PW-1:0]        next_ptr;
  logic [PW:0]          pos;
  logic                 found;
  logic                 accept;

  always_comb begin
    cand = req_valid;
`ifdef PARKING_EXIT_PRIORITY_EN
    if (|(req_valid & req_dir))
      cand = req_valid & req_dir;
`endif
  end

  // Search upward from rr_ptr, wrapping modulo NUM_GATES; first candidate wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      pos = {1'b0, rr_ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_GATES))
        pos = pos - (PW+1)'(NUM_GATES);
      if (!found && cand[pos[PW-1:0]]) begin
        found = 1'b1;
        win   = pos[PW-1:0];
      end
    end
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
    next_ptr = (win == PW'(NUM_GATES - 1)) ? '0 : win + 1'b1;
  end

  // University spaces are reserved, so ordinary cars need room beyond them.
  always_comb begin
    if (req_dir[win])
      accept = 1'b1;
    else if (req_uni[win])
      accept = (uni_vacated_space != '0) && (total_vacated_space != '0);
    else
      accept = total_vacated_space > uni_vacated_space;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      timer              <= '0;
      req_ready          <= '0;
      reject             <= '0;
      gate_open          <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
    end else begin
      req_ready          <= '0;
      reject             <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            req_ready <= win_onehot;
            rr_ptr    <= next_ptr;
            if (accept) begin
              gate_open <= win_onehot;
              timer     <= TW'(GATE_OPEN_CYCLES - 1);
              state     <= OPEN;
              if (req_dir[win]) begin
                car_exited        <= 1'b1;
                is_uni_car_exited <= req_uni[win];
              end else begin
                car_entered        <= 1'b1;
                is_uni_car_entered <= req_uni[win];
              end
            end else begin
              // The acknowledge cycle itself does not count as the settle cycle.
              reject <= win_onehot;
              timer  <= TW'(1);
              state  <= SETTLE;
            end
          end
        end
        OPEN: begin
          if (timer == '0) begin
            gate_open <= '0;
            state     <= SETTLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SETTLE: begin
          if (timer == '0)
            state <= IDLE;
          else
            timer <= timer - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed self-checking bench for parking_gate_scheduler (default parameters: 4 gates, 8-cycle barrier).
module tb_parking_gate_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_dir, req_uni;
  logic [9:0] total_vacated_space, uni_vacated_space;
  logic [3:0] req_ready, reject, gate_open;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, busy;

  int total = 0;
  int bad   = 0;

  parking_gate_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dir(req_dir), .req_uni(req_uni),
    .total_vacated_space(total_vacated_space), .uni_vacated_space(uni_vacated_space),
    .req_ready(req_ready), .reject(reject), .gate_open(gate_open),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] d, input logic [3:0] u,
                               input logic [9:0] tot, input logic [9:0] uv);
    req_valid           = v;
    req_dir             = d;
    req_uni             = u;
    total_vacated_space = tot;
    uni_vacated_space   = uv;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitReady();
    int n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == 4'b0 && n < 8);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 30 && busy; i++) tick();
    checkOutput(tag, 32'(busy), 32'h0);
  endtask

  initial begin
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_gate", 32'(gate_open), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_entered", 32'(car_entered), 32'h0);
    reset = 1'b0;
    tick();

    // Single non-uni entry on gate 0
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 10'd700, 10'd200);
    tick();
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    checkOutput("single_entered", 32'(car_entered), 32'h1);
    checkOutput("single_uni", 32'(is_uni_car_entered), 32'h0);
    checkOutput("single_exited", 32'(car_exited), 32'h0);
    checkOutput("single_gate_t1", 32'(gate_open), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    tick();
    checkOutput("single_ready_pulse", 32'(req_ready), 32'h0);
    checkOutput("single_strobe_pulse", 32'(car_entered), 32'h0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("single_gate_t8", 32'(gate_open), 32'h1);
    tick();
    checkOutput("single_gate_t9", 32'(gate_open), 32'h0);
    checkOutput("single_busy_t9", 32'(busy), 32'h1);
    tick();
    checkOutput("single_busy_t10", 32'(busy), 32'h0);

    // Round-robin: gates 1 and 3 from rr_ptr=0; gate 3 held through gate 1's OPEN
    doReset();
    applyStimulus(4'b1010, 4'b0000, 4'b0000, 10'd700, 10'd200);
    tick();
    checkOutput("rr_first", 32'(req_ready), 32'h2);
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("rr_hold_idle", 32'(req_ready), 32'h0);
    tick();
    checkOutput("rr_second", 32'(req_ready), 32'h8);
    checkOutput("rr_second_gate", 32'(gate_open), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    waitIdle("rr_idle1");
    applyStimulus(4'b1001, 4'b0000, 4'b0000, 10'd700, 10'd200);
    tick();
    checkOutput("rr_wrap", 32'(req_ready), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    waitIdle("rr_idle2");

    // Capacity reject (rr_ptr=1), then uni entry on the same vacancy values
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 10'd200, 10'd200);
    tick();
    checkOutput("cap_ready", 32'(req_ready), 32'h2);
    checkOutput("cap_reject", 32'(reject), 32'h2);
    checkOutput("cap_no_strobe", 32'(car_entered), 32'h0);
    checkOutput("cap_no_gate", 32'(gate_open), 32'h0);
    applyStimulus(4'b0100, 4'b0000, 4'b0100, 10'd200, 10'd200);
    tick();
    checkOutput("cap_holdoff", 32'(req_ready), 32'h0);
    checkOutput("cap_reject_pulse", 32'(reject), 32'h0);
    waitReady();
    checkOutput("uni_ready", 32'(req_ready), 32'h4);
    checkOutput("uni_entered", 32'(car_entered), 32'h1);
    checkOutput("uni_flag", 32'(is_uni_car_entered), 32'h1);
    checkOutput("uni_no_reject", 32'(reject), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd200, 10'd200);
    waitIdle("uni_idle");

    // Boundary: one non-reserved space left admits an ordinary car (rr_ptr=3)
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 10'd201, 10'd200);
    tick();
    checkOutput("edge_accept", 32'(car_entered), 32'h1);
    checkOutput("edge_no_reject", 32'(reject), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd201, 10'd200);
    waitIdle("edge_idle");

    // No uni space: uni car refused (rr_ptr=0)
    applyStimulus(4'b0001, 4'b0000, 4'b0001, 10'd100, 10'd0);
    tick();
    checkOutput("nouni_reject", 32'(reject), 32'h1);
    checkOutput("nouni_no_strobe", 32'(car_entered), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd100, 10'd0);
    waitIdle("nouni_idle");

    // Exit always accepted, even with a full lot
    applyStimulus(4'b0010, 4'b0010, 4'b0010, 10'd0, 10'd0);
    waitReady();
    checkOutput("exit_ready", 32'(req_ready), 32'h2);
    checkOutput("exit_strobe", 32'(car_exited), 32'h1);
    checkOutput("exit_uni", 32'(is_uni_car_exited), 32'h1);
    checkOutput("exit_no_entered", 32'(car_entered), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    waitIdle("exit_idle");

    // Entry on gate 0 and exit on gate 2 pending together, rr_ptr=0
    doReset();
    applyStimulus(4'b0101, 4'b0100, 4'b0000, 10'd700, 10'd200);
    tick();
`ifdef PARKING_EXIT_PRIORITY_EN
    checkOutput("prio_ready", 32'(req_ready), 32'h4);
    checkOutput("prio_exited", 32'(car_exited), 32'h1);
    checkOutput("prio_entered", 32'(car_entered), 32'h0);
`else
    checkOutput("prio_ready", 32'(req_ready), 32'h1);
    checkOutput("prio_exited", 32'(car_exited), 32'h0);
    checkOutput("prio_entered", 32'(car_entered), 32'h1);
`endif
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);

    // Reset three cycles into OPEN; gates 0 and 3 stay valid so rr_ptr is visible
    doReset();
    applyStimulus(4'b1001, 4'b0000, 4'b0000, 10'd700, 10'd200);
    tick();
    checkOutput("mid_first", 32'(req_ready), 32'h1);
    tick();
    tick();
    tick();
    checkOutput("mid_open_before", 32'(gate_open), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mid_gate_drop", 32'(gate_open), 32'h0);
    checkOutput("mid_busy", 32'(busy), 32'h0);
    checkOutput("mid_ready", 32'(req_ready), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("mid_regrant", 32'(req_ready), 32'h1);
    checkOutput("mid_regrant_gate", 32'(gate_open), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'd700, 10'd200);
    waitIdle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
